// File: rtl/life_step_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : life_step_controller
//  Purpose  : Sequences one Game-of-Life (B3/S23) generation over the arena.
//             Cells are visited in row-major order. For each cell the 3x3
//             neighbourhood is read through a 1-cycle read port (k = 0..8,
//             k = 4 is the cell itself). The live-neighbour count is
//             accumulated, and the next state is written to the back buffer
//             in a single WRITE cycle.
//  Ports    : clk        - system clock, rising edge
//             reset      - asynchronous active-low reset
//             step_start - request one generation (sampled only in IDLE)
//             step_busy  - high in READ and WRITE
//             step_done  - one-cycle pulse after the last cell is written
//             rd_start / rd_ready / rd_column / rd_row / rd_value
//                        - cell read port; rd_value is valid with rd_ready
//             wr_en / wr_column / wr_row / wr_value
//                        - next-generation write strobe and data
//  Options  : LIFE_TORUS_EN - when defined, neighbour coordinates wrap
//             around the arena edges, so all 9 reads are always issued.
//             When undefined, off-arena neighbours count as dead and no
//             read is issued for them. A cell still takes 9 cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module life_step_controller #(
    parameter int ARENA_WIDTH  = 10,
    parameter int ARENA_HEIGHT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step_start,
    output logic       step_busy,
    output logic       step_done,
    output logic       rd_start,
    input  logic       rd_ready,
    output logic [7:0] rd_column,
    output logic [7:0] rd_row,
    input  logic       rd_value,
    output logic       wr_en,
    output logic [7:0] wr_column,
    output logic [7:0] wr_row,
    output logic       wr_value
);

    localparam logic [7:0] c_LAST_COL = 8'(ARENA_WIDTH - 1);
    localparam logic [7:0] c_LAST_ROW = 8'(ARENA_HEIGHT - 1);
    localparam logic [8:0] c_WIDTH9   = 9'(ARENA_WIDTH);
    localparam logic [8:0] c_HEIGHT9  = 9'(ARENA_HEIGHT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_col;
    logic [7:0] r_row;
    logic [3:0] r_k;
    logic [3:0] r_cnt;
    logic       r_self;

    logic [1:0] w_cidx;
    logic [1:0] w_ridx;
    logic [8:0] w_ncol_raw;
    logic [8:0] w_nrow_raw;
    logic [7:0] w_ncol;
    logic [7:0] w_nrow;
    logic       w_inb;
    logic       w_advance;
    logic       w_sample;
    logic       w_last_cell;

    // Neighbour index k -> (row offset + 1, column offset + 1).
    always_comb begin
        w_ridx = 2'd2;
        w_cidx = 2'd2;
        case (r_k)
            4'd0: begin w_ridx = 2'd0; w_cidx = 2'd0; end
            4'd1: begin w_ridx = 2'd0; w_cidx = 2'd1; end
            4'd2: begin w_ridx = 2'd0; w_cidx = 2'd2; end
            4'd3: begin w_ridx = 2'd1; w_cidx = 2'd0; end
            4'd4: begin w_ridx = 2'd1; w_cidx = 2'd1; end
            4'd5: begin w_ridx = 2'd1; w_cidx = 2'd2; end
            4'd6: begin w_ridx = 2'd2; w_cidx = 2'd0; end
            4'd7: begin w_ridx = 2'd2; w_cidx = 2'd1; end
            default: begin w_ridx = 2'd2; w_cidx = 2'd2; end
        endcase
    end

    // 9-bit neighbour coordinates: -1 becomes 9'h1FF, and one past the last
    // column/row becomes W/H. Both values are >= the arena size, so a
    // single unsigned compare detects "off the arena".
    assign w_ncol_raw = {1'b0, r_col} + {7'b0, w_cidx} - 9'd1;
    assign w_nrow_raw = {1'b0, r_row} + {7'b0, w_ridx} - 9'd1;

`ifdef LIFE_TORUS_EN
    always_comb begin
        if (w_ncol_raw == 9'h1FF)
            w_ncol = c_LAST_COL;
        else if (w_ncol_raw == c_WIDTH9)
            w_ncol = 8'd0;
        else
            w_ncol = w_ncol_raw[7:0];

        if (w_nrow_raw == 9'h1FF)
            w_nrow = c_LAST_ROW;
        else if (w_nrow_raw == c_HEIGHT9)
            w_nrow = 8'd0;
        else
            w_nrow = w_nrow_raw[7:0];

        w_inb = 1'b1;
    end
`else
    assign w_ncol = w_ncol_raw[7:0];
    assign w_nrow = w_nrow_raw[7:0];
    assign w_inb  = (w_ncol_raw < c_WIDTH9) && (w_nrow_raw < c_HEIGHT9);
`endif

    // An off-arena neighbour is consumed in one cycle as a dead cell.
    assign w_advance   = !w_inb || rd_ready;
    assign w_sample    = w_inb && rd_value;
    assign w_last_cell = (r_col == c_LAST_COL) && (r_row == c_LAST_ROW);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // ------------------------------------------------------------------
    // Next-state and output decode (outputs depend only on registers,
    // so an asynchronous reset clears them immediately)
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        step_busy   = 1'b0;
        step_done   = 1'b0;
        rd_start    = 1'b0;
        rd_column   = 8'd0;
        rd_row      = 8'd0;
        wr_en       = 1'b0;
        wr_column   = 8'd0;
        wr_row      = 8'd0;
        wr_value    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (step_start)
                    w_state_nxt = S_READ;
            end
            S_READ: begin
                step_busy = 1'b1;
                if (w_inb) begin
                    rd_start  = 1'b1;
                    rd_column = w_ncol;
                    rd_row    = w_nrow;
                end
                if (w_advance && (r_k == 4'd8))
                    w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                step_busy = 1'b1;
                wr_en     = 1'b1;
                wr_column = r_col;
                wr_row    = r_row;
                wr_value  = (r_cnt == 4'd3) || (r_self && (r_cnt == 4'd2));
                w_state_nxt = w_last_cell ? S_DONE : S_READ;
            end
            default: begin
                step_done   = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Cursor, neighbour index and live-neighbour accumulator
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_col  <= 8'd0;
            r_row  <= 8'd0;
            r_k    <= 4'd0;
            r_cnt  <= 4'd0;
            r_self <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (step_start) begin
                        r_col  <= 8'd0;
                        r_row  <= 8'd0;
                        r_k    <= 4'd0;
                        r_cnt  <= 4'd0;
                        r_self <= 1'b0;
                    end
                end
                S_READ: begin
                    if (w_advance) begin
                        // The centre cell selects survival; it is not a neighbour.
                        if (r_k == 4'd4)
                            r_self <= w_sample;
                        else
                            r_cnt <= r_cnt + {3'b0, w_sample};
                        if (r_k != 4'd8)
                            r_k <= r_k + 4'd1;
                    end
                end
                S_WRITE: begin
                    r_k    <= 4'd0;
                    r_cnt  <= 4'd0;
                    r_self <= 1'b0;
                    if (r_col == c_LAST_COL) begin
                        r_col <= 8'd0;
                        r_row <= (r_row == c_LAST_ROW) ? 8'd0 : r_row + 8'd1;
                    end else begin
                        r_col <= r_col + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/life_step_controller.md
Name: life_step_controller

Overview:
- Sequences one Game-of-Life generation over the arena using the 1-cycle cell read port (start/ready, column/row, value).
- For each cell in row-major order it reads the cell and its 8 neighbours, counts live neighbours, applies the B3/S23 rule and writes the next state.
- Writes go to the next-generation (back) buffer; buffer swapping is owned by the top level.

Parameters:
- ARENA_WIDTH, 10, number of columns (2..256).
- ARENA_HEIGHT, 10, number of rows (2..256).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- step_start  in  1  request one generation; sampled only in IDLE.
- step_busy  out  1  high while a generation is in progress.
- step_done  out  1  one-cycle pulse after the last cell is written.
- rd_start  out  1  cell read request.
- rd_ready  in  1  read accepted; rd_value is valid in the same cycle.
- rd_column  out  8  column of the cell being read.
- rd_row  out  8  row of the cell being read.
- rd_value  in  1  current-generation cell value.
- wr_en  out  1  next-state write strobe.
- wr_column  out  8  column being written.
- wr_row  out  8  row being written.
- wr_value  out  1  next-generation value.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE.
  - All outputs 0; cursor (col,row)=(0,0); neighbour index k=0; count=0.
  - Reset mid-generation aborts immediately: no further reads or writes; the bench ignores the partial back buffer.
- States:
  - IDLE -> READ on step_start=1. Cursor cleared to (0,0).
  - READ: one neighbour per k=0..8, offsets (dr,dc) in row-major order from (-1,-1) to (+1,+1); k=4 is the cell itself.
    - In-bounds neighbour: rd_start=1, rd_column=col+dc, rd_row=row+dr.
    - If rd_ready=1 that cycle: capture rd_value and advance k. If rd_ready=0: hold rd_start and coordinates stable and stay.
    - Out-of-bounds neighbour: rd_start=0, contributes 0, k advances in 1 cycle.
    - After k=8 is consumed -> WRITE.
  - WRITE: exactly 1 cycle.
    - wr_en=1, wr_column=col, wr_row=row, wr_value=(n==3)|(self&(n==2)). n is a 4-bit count of live neighbours excluding self, range 0..8.
    - Then clear n and k and advance the cursor: col+1; at col=ARENA_WIDTH-1 wrap col to 0 and row+1.
    - Last cell (W-1,H-1) -> DONE; otherwise -> READ.
  - DONE: step_done=1 for 1 cycle, step_busy=0, -> IDLE.
- step_busy=1 exactly in READ and WRITE.
- Timing with rd_ready tied 1 and step_start sampled at cycle 0:
  - busy is high from cycle 1 through 10*W*H; step_done is at cycle 10*W*H+1.
  - Each rd_ready=0 cycle adds one cycle.
- step_start is ignored while busy or in DONE; no queuing.
- rd_column/rd_row are meaningful only while rd_start=1 and are otherwise 0.
- wr_column/wr_row/wr_value are meaningful only while wr_en=1 and are otherwise 0.
- At most one of rd_start and wr_en is high in any cycle.

Optional Feature:
- Macro LIFE_TORUS_EN.
- Defined: the arena is a torus. Neighbour coordinates wrap modulo ARENA_WIDTH/ARENA_HEIGHT (-1 -> W-1 or H-1, W -> 0, H -> 0), so all 9 reads are always issued.
- Undefined: out-of-bounds neighbours are dead and no read is issued for them (timing unchanged, 9 cycles per cell).

Test Plan:
- Blinker, 5x5, no torus, ready=1: live cells (1,2),(2,2),(3,2) as (col,row); pulse step_start -> 25 writes in row-major order; exactly (2,1),(2,2),(2,3) written as 1; step_done at cycle 251; cell (0,0) issues exactly 4 reads.
- Block still-life, 4x4, no torus: cells (1,1),(2,1),(1,2),(2,2) live -> the same 4 cells written 1, all others 0.
- Torus wrap, 5x5, LIFE_TORUS_EN: live cells (0,0),(1,0),(2,0) -> (1,4),(1,0),(1,1) written 1, all else 0. Same stimulus without the macro -> only (1,0),(1,1) written 1.
- Backpressure: rd_ready=0 for 3 cycles on the first read -> rd_start, rd_column and rd_row held constant; results identical; step_done delayed by exactly 3 cycles.
- Reset mid-run: assert reset at cycle 37 -> all outputs 0 in the same cycle (async). After release, no activity until step_start; a new step then completes normally.
- step_start held high throughout -> only one generation per IDLE entry. A pulse during busy is ignored; a step_start high in the cycle after DONE (IDLE) starts a new generation.
